range_finder_button_poller: RTL and testbench

Avalon-MM read master that periodically polls the range finder's 2-bit button PIO slave and debounces the sampled key levels. It is the initiator end of the button PIO interface and emits one-cycle press/release pulses, stable levels, and a buffered press-event word with a valid/ready handshake for the measurement control logic. It removes software polling of the keys from the Nios loop.

---
 rtl/range_finder_button_poller_if.sv | 26 ++
 rtl/range_finder_button_poller.sv | 217 +++++++++++++++++++++
 tb/tb_range_finder_button_poller.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_finder_button_poller_if.sv
// Avalon-MM read channel between the button poller (master) and the range
// finder's 2-bit button PIO (slave).
//   avm_address     master -> slave  word address of the PIO data register
//   avm_read        master -> slave  read request, held while stalled
//   avm_waitrequest slave  -> master stall; the request is accepted when low
//   avm_readdata    slave  -> master read data, bits [1:0] are the raw keys
interface range_finder_button_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/range_finder_button_poller.sv
// Periodic Avalon-MM poller for the range finder's two push buttons.
// It reads the button PIO every POLL_DIV idle cycles and debounces the
// active-low key levels. It also produces one-cycle press/release pulses and
// keeps a press-event word with a valid/ready handshake for the measurement
// control logic.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   avm             Avalon-MM master port (address, read, waitrequest, readdata)
//   btn_stable      debounced key levels, 1 = pressed
//   press_pulse     one-cycle pulse per bit on a debounced press
//   release_pulse   one-cycle pulse per bit on a debounced release
//   event_valid     a press event is pending
//   event_data      accumulated press mask since the last accept
//   event_overflow  sticky: a bit was pressed again while still pending
//   event_ready     consumer accepts the pending event
module range_finder_button_poller #(
  parameter int         POLL_DIV     = 50000,
  parameter int         DEBOUNCE_N   = 4,
  parameter int         READ_LATENCY = 1,
  parameter logic [1:0] PIO_ADDR     = 2'd0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  range_finder_button_poller_if.master        avm,
  output logic [1:0]                          btn_stable,
  output logic [1:0]                          press_pulse,
  output logic [1:0]                          release_pulse,
  output logic                                event_valid,
  output logic [1:0]                          event_data,
  output logic                                event_overflow,
  input  logic                                event_ready
);

  localparam int         TIMER_W    = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 2;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
  // WAIT covers READ_LATENCY-1 cycles; its counter runs 0 .. READ_LATENCY-2.
  localparam logic [1:0] WAIT_LAST  = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t               state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [1:0]           wait_reg, wait_next;
  logic                 avm_read_reg;

  logic [1:0]           btn_stable_reg, btn_stable_next;
  logic [1:0]           press_reg, press_next;
  logic [1:0]           release_reg, release_next;
  logic                 event_valid_reg, event_valid_next;
  logic [1:0]           event_data_reg, event_data_next;
  logic                 event_overflow_reg, event_overflow_next;

  logic                 capture;
  logic [1:0]           sample;
  logic                 event_accept;
  logic                 unused_readdata;

  // ---------------------------------------------------------------------------
  // Poll sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    wait_next  = wait_reg;
    case (state_reg)
      ST_IDLE: begin
        if (timer_reg == TIMER_LAST) begin
          timer_next = '0;
          state_next = ST_REQ;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_REQ: begin
        if (!avm.avm_waitrequest) begin
          wait_next  = '0;
          state_next = (READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next = ST_CAPTURE;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      wait_reg     <= '0;
      avm_read_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      wait_reg     <= wait_next;
      // Registered copy of "in REQ", so it stays high through waitrequest.
      avm_read_reg <= (state_next == ST_REQ);
    end
  end

  assign avm.avm_address = PIO_ADDR;
  assign avm.avm_read    = avm_read_reg;

  // Keys are active-low on the PIO; only bits [1:0] carry information.
  assign capture         = (state_reg == ST_CAPTURE);
  assign sample          = ~avm.avm_readdata[1:0];
  assign unused_readdata = ^avm.avm_readdata[31:2];

  // ---------------------------------------------------------------------------
  // Per-bit debounce: DEBOUNCE_N consecutive disagreeing samples flip the
  // stable level; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bit
      logic [3:0] cnt_reg, cnt_next;
      logic       stable_n, press_n, release_n;

      always_comb begin
        cnt_next  = cnt_reg;
        stable_n  = btn_stable_reg[gi];
        press_n   = 1'b0;
        release_n = 1'b0;
        if (capture) begin
          if (sample[gi] == btn_stable_reg[gi]) begin
            cnt_next = '0;
          end else if (cnt_reg + 4'd1 == DEB_LAST) begin
            cnt_next  = '0;
            stable_n  = sample[gi];
            press_n   = sample[gi];
            release_n = ~sample[gi];
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign btn_stable_next[gi] = stable_n;
      assign press_next[gi]      = press_n;
      assign release_next[gi]    = release_n;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Press-event buffer. A press arriving in the accept cycle starts a fresh
  // mask instead of being merged into the one being consumed.
  // ---------------------------------------------------------------------------
  assign event_accept = event_valid_reg && event_ready;

  always_comb begin
    event_valid_next    = event_valid_reg;
    event_data_next     = event_data_reg;
    event_overflow_next = event_overflow_reg;
    if (event_accept) begin
      event_data_next  = press_next;
      event_valid_next = |press_next;
    end else if (|press_next) begin
      event_data_next  = event_data_reg | press_next;
      event_valid_next = 1'b1;
      if (|(event_data_reg & press_next)) begin
        event_overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_stable_reg     <= '0;
      press_reg          <= '0;
      release_reg        <= '0;
      event_valid_reg    <= 1'b0;
      event_data_reg     <= '0;
      event_overflow_reg <= 1'b0;
    end else begin
      btn_stable_reg     <= btn_stable_next;
      press_reg          <= press_next;
      release_reg        <= release_next;
      event_valid_reg    <= event_valid_next;
      event_data_reg     <= event_data_next;
      event_overflow_reg <= event_overflow_next;
    end
  end

  assign btn_stable     = btn_stable_reg;
  assign press_pulse    = press_reg;
  assign release_pulse  = release_reg;
  assign event_valid    = event_valid_reg;
  assign event_data     = event_data_reg;
  assign event_overflow = event_overflow_reg;

endmodule

// File: tb/tb_range_finder_button_poller.sv
// Bench for range_finder_button_poller. Main instance: POLL_DIV=8,
// DEBOUNCE_N=3, READ_LATENCY=1. Second instance: POLL_DIV=4, DEBOUNCE_N=1,
// READ_LATENCY=3. Each slave model returns real key data only on the cycle
// the read data is due and inverted keys on every other cycle.
module tb_range_finder_button_poller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- main instance ----------------
  range_finder_button_poller_if bus ();
  logic [1:0] btn_stable, press_pulse, release_pulse, event_data;
  logic       event_valid, event_overflow;
  logic       event_ready = 1'b0;

  logic [1:0] key_raw = 2'b11;
  int         stall_target = 0;
  int         stall_done;
  logic [2:0] pipe;

  range_finder_button_poller #(
    .POLL_DIV(8), .DEBOUNCE_N(3), .READ_LATENCY(1), .PIO_ADDR(2'd1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avm(bus),
    .btn_stable(btn_stable), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_valid(event_valid), .event_data(event_data),
    .event_overflow(event_overflow), .event_ready(event_ready)
  );

  assign bus.avm_waitrequest = bus.avm_read && (stall_done < stall_target);
  assign bus.avm_readdata    = pipe[0] ? {30'h2AAAAAAA, key_raw} : {30'h15555555, ~key_raw};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe       <= '0;
      stall_done <= 0;
    end else begin
      pipe <= {pipe[1:0], bus.avm_read & ~bus.avm_waitrequest};
      if (!bus.avm_read) stall_done <= 0;
      else if (bus.avm_waitrequest) stall_done <= stall_done + 1;
    end
  end

  // ---------------- READ_LATENCY=3 instance ----------------
  range_finder_button_poller_if bus3 ();
  logic [1:0] btn_stable3, press_pulse3, release_pulse3, event_data3;
  logic       event_valid3, event_overflow3;
  logic       event_ready3 = 1'b0;

  logic [1:0] key_raw3 = 2'b11;
  int         stall3_target = 0;
  int         stall3_done;
  logic [2:0] pipe3;

  range_finder_button_poller #(
    .POLL_DIV(4), .DEBOUNCE_N(1), .READ_LATENCY(3), .PIO_ADDR(2'd2)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .avm(bus3),
    .btn_stable(btn_stable3), .press_pulse(press_pulse3), .release_pulse(release_pulse3),
    .event_valid(event_valid3), .event_data(event_data3),
    .event_overflow(event_overflow3), .event_ready(event_ready3)
  );

  assign bus3.avm_waitrequest = bus3.avm_read && (stall3_done < stall3_target);
  assign bus3.avm_readdata    = pipe3[2] ? {30'h2AAAAAAA, key_raw3} : {30'h15555555, ~key_raw3};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe3       <= '0;
      stall3_done <= 0;
    end else begin
      pipe3 <= {pipe3[1:0], bus3.avm_read & ~bus3.avm_waitrequest};
      if (!bus3.avm_read) stall3_done <= 0;
      else if (bus3.avm_waitrequest) stall3_done <= stall3_done + 1;
    end
  end

  // ---------------- scoreboard ----------------
  // Record: {press, release, stable, valid, data, overflow}
  logic [9:0] sb_q[$];

  function automatic logic [9:0] pk(input logic [1:0] p, input logic [1:0] r,
                                    input logic [1:0] s, input logic v,
                                    input logic [1:0] d, input logic o);
    return {p, r, s, v, d, o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic run_monitor();
    logic [9:0] act;
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (reset_n && ((press_pulse | release_pulse) != 2'b00)) begin
        act = pk(press_pulse, release_pulse, btn_stable, event_valid, event_data, event_overflow);
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got %b expected none at %0t", act, $time);
        end else begin
          exp = sb_q.pop_front();
          if (act !== exp) begin
            fails++;
            $display("FAIL event_record: got %b expected %b at %0t", act, exp, $time);
          end else begin
            $display("[TB] event p=%b r=%b s=%b v=%b d=%b o=%b", act[9:8], act[7:6],
                     act[5:4], act[3], act[2:1], act[0]);
          end
        end
      end
    end
  endtask

  // One poll on the main instance: returns just after the capture edge.
  task automatic poll(input logic [1:0] raw, input int stall, input bit ready_in_capture,
                      input int exp_hi);
    int hi;
    bit ok;
    key_raw      = raw;
    stall_target = stall;
    hi = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.avm_read) hi++;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL poll_timeout: got no accept expected accept within 100 cycles");
    end else begin
      @(posedge clk); #1;
      if (ready_in_capture) event_ready = 1'b1;
      @(posedge clk); #1;
      event_ready = 1'b0;
      if (exp_hi > 0) check("req_len", 32'(hi), 32'(exp_hi));
    end
    stall_target = 0;
  endtask

  task automatic consume();
    @(negedge clk);
    event_ready = 1'b1;
    @(posedge clk); #1;
    event_ready = 1'b0;
    check("consume_valid", {31'd0, event_valid}, 32'd0);
    check("consume_data", {30'd0, event_data}, 32'd0);
  endtask

  initial begin
    int  hi3;
    bit  ok;
    fork
      run_monitor();
    join_none

    // ---- reset state ----
    #1;
    check("rst_read", {31'd0, bus.avm_read}, 32'd0);
    check("rst_addr", {30'd0, bus.avm_address}, 32'd1);
    check("rst_outputs", {22'd0, pk(press_pulse, release_pulse, btn_stable,
                                    event_valid, event_data, event_overflow)}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ---- poll timing: first read after 8 edges, period 10, 1 cycle wide ----
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 7 || k == 8 || k == 9 || k == 17 || k == 18)
        check($sformatf("read_at_%0d", k), {31'd0, bus.avm_read}, (k == 8 || k == 18) ? 32'd1 : 32'd0);
    end

    // ---- clean press then release of bit0 ----
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    check("pre_press_stable", {30'd0, btn_stable}, 32'd0);
    sb_q.push_back(pk(2'b01, 2'b00, 2'b01, 1'b1, 2'b01, 1'b0));
    poll(2'b10, 0, 1'b0, 0);
    check("press_pulse_now", {30'd0, press_pulse}, 32'd1);
    @(posedge clk); #1;
    check("press_pulse_gone", {30'd0, press_pulse}, 32'd0);
    poll(2'b11, 0, 1'b0, 1);
    poll(2'b11, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0));
    poll(2'b11, 0, 1'b0, 0);
    check("release_keeps_event", {29'd0, event_valid, event_data}, 32'h5);
    consume();

    // ---- bounce: broken run gives nothing, a clean run of 3 presses ----
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b11, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    check("bounce_hold", {30'd0, btn_stable}, 32'd0);
    sb_q.push_back(pk(2'b01, 2'b00, 2'b01, 1'b1, 2'b01, 1'b0));
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b11, 0, 1'b0, 0);
    poll(2'b11, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0));
    poll(2'b11, 0, 1'b0, 0);
    consume();

    // ---- event handshake and overflow ----
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b01, 2'b00, 2'b01, 1'b1, 2'b01, 1'b0));
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b10, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0));
    poll(2'b00, 0, 1'b0, 0);
    check("no_overflow_yet", {31'd0, event_overflow}, 32'd0);
    poll(2'b01, 0, 1'b0, 0);
    poll(2'b01, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b00, 2'b01, 2'b10, 1'b1, 2'b11, 1'b0));
    poll(2'b01, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b01, 2'b00, 2'b11, 1'b1, 2'b11, 1'b1));
    poll(2'b00, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b10, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b00, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1));
    poll(2'b10, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    poll(2'b00, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b10, 2'b00, 2'b11, 1'b1, 2'b10, 1'b1));
    poll(2'b00, 0, 1'b1, 0);
    check("accept_with_press", {29'd0, event_valid, event_data}, 32'h6);

    // ---- waitrequest stall on the capturing poll ----
    poll(2'b11, 0, 1'b0, 1);
    poll(2'b11, 0, 1'b0, 0);
    sb_q.push_back(pk(2'b00, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1));
    poll(2'b11, 5, 1'b0, 6);
    check("addr_const", {30'd0, bus.avm_address}, 32'd1);

    // ---- READ_LATENCY=3 instance: sample exactly 3 cycles after accept ----
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus3.avm_read && !bus3.avm_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL rl3_timeout: got no accept expected accept within 100 cycles");
    end else begin
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check("rl3_idle_stable", {30'd0, btn_stable3}, 32'd0);
      key_raw3      = 2'b10;
      stall3_target = 5;
      hi3 = 0;
      ok  = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus3.avm_read) hi3++;
        if (bus3.avm_read && !bus3.avm_waitrequest) begin
          ok = 1'b1;
          break;
        end
      end
      check("rl3_req_len", 32'(hi3), 32'd6);
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("rl3_not_early", {30'd0, press_pulse3}, 32'd0);
      @(posedge clk); #1;
      check("rl3_stable", {30'd0, btn_stable3}, 32'd1);
      check("rl3_press", {30'd0, press_pulse3}, 32'd1);
      check("rl3_addr", {30'd0, bus3.avm_address}, 32'd2);
      stall3_target = 0;
    end

    // ---- asynchronous reset in the middle of a stalled request ----
    key_raw      = 2'b11;
    stall_target = 5;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.avm_read) begin
        ok = 1'b1;
        break;
      end
    end
    check("reset_found_req", {31'd0, ok}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_read_drop", {31'd0, bus.avm_read}, 32'd0);
    check("async_state_clear", {22'd0, pk(press_pulse, release_pulse, btn_stable,
                                          event_valid, event_data, event_overflow)}, 32'd0);
    stall_target = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k >= 7)
        check($sformatf("post_rst_read_%0d", k), {31'd0, bus.avm_read}, (k == 8) ? 32'd1 : 32'd0);
    end

    repeat (20) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
